imem_loader: RTL and testbench
==============================

# imem_loader

Synthesizable program loader that fills the instruction memory from a byte stream (e.g. a UART receiver) and holds the core until the program is in place. It is the write-side counterpart to the fetch path: it zero-fills the memory, then writes big-endian 32-bit words, with the first byte in bits [31:24], at consecutive word addresses. It sits between the byte source and the instruction memory write port, and drives the core's hold signal.

## Interface
- `DEPTH`, 1024: instruction memory depth in 32-bit words.
- `ADDR_W`, 10: word address width; `2**ADDR_W >= DEPTH`.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
- `in_valid`  in  1: byte source has data.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte; a transfer occurs when `in_valid && in_ready`.
- `mem_we`  out  1: one-cycle write strobe to instruction memory.
- `mem_addr`  out  ADDR_W: word address.
- `mem_wdata`  out  32: write data.
- `cpu_hold`  out  1: keeps the core in reset while high.
- `done`  out  1: program loaded.
- `error`  out  1: header word count exceeds `DEPTH`.
- `words_loaded`  out  ADDR_W+1: number of payload words written in the current load.

## Operation
- Stream format:
  - 2-byte header giving the word count N, big-endian (high byte first).
  - Then N×4 payload bytes; each word is sent MSB first.
- States and transitions:
  - IDLE: waits for `start`, then goes to CLEAR.
  - CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle, with `in_ready=0`. Goes to HDR.
  - HDR: `in_ready=1`; accepts the high byte, then the low byte. Goes to DONE if N=0, to ERR if N>DEPTH, otherwise to LOAD.
  - LOAD: `in_ready=1`. A byte index 0..3 shifts bytes into the word assembler. On the 4th byte the loader issues a write and increments the word index.
    - After write number N: go to DONE.
  - DONE: `done=1`, `cpu_hold=0`, `in_ready=0`.
  - ERR: `error=1`, `cpu_hold=1`, `in_ready=0`; no payload writes.
- `start` in any other state is ignored.
- `start` in DONE or ERR:
  - clears `done`, `error` and `words_loaded`;
  - reasserts `cpu_hold`;
  - re-enters CLEAR.
- Bytes presented in IDLE, CLEAR, DONE and ERR are not consumed (`in_ready=0`).
- `rst` at any point, including mid-CLEAR and mid-LOAD:
  - returns to IDLE on the next edge;
  - discards any partial word;
  - does not clean up memory contents.
- Reset values: `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_hold=1`, `done=0`, `error=0`, `words_loaded=0`.
- All outputs are registered.

## Timing
- `start` sampled at edge T: first clear write (`mem_we=1`, addr 0, data 0) is at T+1; last clear write (addr DEPTH-1) is at T+DEPTH.
- `in_ready=1` from T+DEPTH+1, in HDR.
- 4th byte of a word accepted at edge E: `mem_we=1` with that word's address and data during E+1. `in_ready` stays high, so the next word's bytes may transfer back-to-back.
- `words_loaded` increments in the same cycle as the `mem_we` pulse.
- Last write at E+1: `done=1` and `cpu_hold=0` at E+2.
- ERR and N=0 cases: header low byte accepted at edge H; `error=1` (or `done=1`) from H+1.
- Stalls: `in_valid` gaps of any length only delay the sequence; no byte is dropped or duplicated.
- Maximum throughput is one byte per cycle; `mem_we` is never high on consecutive cycles in LOAD.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum `loader_state_t`;
  - `IMEM_DEPTH=1024` and `IMEM_ADDR_W=10`, also used by the instruction memory so the two cannot drift.
- Sub-module `imem_word_packer`: byte index counter plus 32-bit shift register. It takes byte, strobe and clear inputs and produces `word_valid` and `word`.
- The top level holds the FSM, address/clear counter, header register and output registers.

## Test plan
Scenarios 1–6 use `DEPTH=8`.
1. Reset, `start`, header 00 02, bytes 00 00 00 13 DE AD BE EF: zeros written to 0..7, then addr 0 = 0x00000013 and addr 1 = 0xDEADBEEF. Result `words_loaded=2`, `done=1`, `cpu_hold=0`.
2. Header 00 09: after CLEAR no payload writes occur; `error=1`, `cpu_hold=1`, `in_ready=0`.
3. Header 00 00: 8 clear writes only, then `done=1` on the cycle after the header low byte.
4. Same stream as 1 with `in_valid` high every third cycle: identical write sequence and data.
5. `rst` after 5 payload bytes: all outputs at reset values next cycle. A new `start` with the full stream from scenario 1 reproduces the scenario 1 results.
6. `start` pulsed during LOAD is ignored. `start` after DONE gives `cpu_hold=1` and `done=0` next cycle, then a clear write to addr 0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the program loader and the instruction memory.
//   loader_state_t : loader FSM state encoding
//   IMEM_DEPTH     : instruction memory depth in 32-bit words
//   IMEM_ADDR_W    : word address width (2**IMEM_ADDR_W >= IMEM_DEPTH)
package imem_pkg;

  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HDR   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles four stream bytes, MSB first, into a 32-bit word.
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   clear      in  : discards any partially assembled word
//   strobe     in  : byte_data is valid and consumed this cycle
//   byte_data  in  : stream byte
//   word_valid out : high in the cycle the 4th byte is strobed in
//   word       out : assembled word, valid while word_valid is high
// word_valid/word are combinational so the parent can register the write in
// the same edge that accepts the 4th byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_r;
  logic [23:0] shift_r;

  assign word_valid = strobe && (idx_r == 2'd3);
  assign word       = {shift_r, byte_data};

  // Byte index and shift register; the index wraps 3 -> 0 after a full word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (strobe) begin
      idx_r   <= idx_r + 2'd1;
      shift_r <= {shift_r[15:0], byte_data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream and holds the
// core in reset until the program is in place.
// Stream: 2-byte big-endian word count N, then N big-endian 32-bit words.
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid/in_data     : byte source
//   in_ready             : byte accepted when in_valid && in_ready
//   mem_we/addr/wdata    : instruction memory write port
//   cpu_hold             : core held in reset while high
//   done / error         : load complete / header count exceeds DEPTH
//   words_loaded         : payload words written in the current load
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t    state_r;
  logic             hdr_hi_seen_r;
  logic [7:0]       hdr_hi_r;
  logic [CNT_W-1:0] word_count_r;

  logic        xfer_s;
  logic        pack_strobe_s;
  logic        pack_clear_s;
  logic        word_valid_s;
  logic [31:0] word_s;
  logic [15:0] hdr_n_s;

  assign xfer_s        = in_valid && in_ready;
  assign pack_strobe_s = xfer_s && (state_r == ST_LOAD);
  assign pack_clear_s  = (state_r != ST_LOAD);
  assign hdr_n_s       = {hdr_hi_r, in_data};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_s),
    .strobe     (pack_strobe_s),
    .byte_data  (in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Loader FSM with all outputs registered. mem_addr doubles as the clear
  // counter; words_loaded doubles as the payload word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      hdr_hi_seen_r <= 1'b0;
      hdr_hi_r      <= 8'd0;
      word_count_r  <= '0;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'd0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            // First clear write is issued straight away.
            state_r       <= ST_CLEAR;
            mem_we        <= 1'b1;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            in_ready      <= 1'b0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_loaded  <= '0;
            hdr_hi_seen_r <= 1'b0;
          end else if (state_r == ST_DONE) begin
            // Reached one cycle after the last payload write.
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (mem_addr == ADDR_W'(DEPTH - 1)) begin
            state_r  <= ST_HDR;
            in_ready <= 1'b1;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= 32'd0;
          end
        end
        ST_HDR: begin
          if (xfer_s) begin
            if (!hdr_hi_seen_r) begin
              hdr_hi_r      <= in_data;
              hdr_hi_seen_r <= 1'b1;
            end else begin
              hdr_hi_seen_r <= 1'b0;
              if (hdr_n_s == 16'd0) begin
                state_r  <= ST_DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else if ({1'b0, hdr_n_s} > 17'(DEPTH)) begin
                state_r  <= ST_ERR;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else begin
                state_r      <= ST_LOAD;
                word_count_r <= CNT_W'(hdr_n_s);
              end
            end
          end
        end
        ST_LOAD: begin
          if (word_valid_s) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= word_s;
            words_loaded <= words_loaded + CNT_W'(1);
            // Stop accepting bytes once the final word is written; done
            // follows one cycle after the write.
            if ((words_loaded + CNT_W'(1)) == word_count_r) begin
              state_r  <= ST_DONE;
              in_ready <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t wr_log[$];

  typedef struct {
    logic [7:0]       hdr_hi;
    logic [7:0]       hdr_lo;
    int               n_words;
    logic [7:0][31:0] words;
    int               gap;
    bit               start_mid;
    bit               exp_done;
    bit               exp_error;
    int               exp_writes;
  } vec_t;

  vec_t vecs[7];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 100) begin
      step();
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pulse_start_and_clear();
    int k = 0;
    wr_log.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
    check("start_words", 32'(words_loaded), 32'd0);
    check("start_we", 32'(mem_we), 32'd1);
    check("start_addr", 32'(mem_addr), 32'd0);
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check("clear_cycles", 32'(k), 32'(DEPTH));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k = 0;
    logic [7:0] b;
    bit last;
    pulse_start_and_clear();
    send_byte(v.hdr_hi, v.gap);
    send_byte(v.hdr_lo, (v.n_words == 0) ? 0 : v.gap);
    for (int w = 0; w < v.n_words; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = v.words[w][31 - 8*j -: 8];
        last = (w == v.n_words - 1) && (j == 3);
        if (v.start_mid && w == 0 && j == 2) start = 1'b1;
        send_byte(b, last ? 0 : v.gap);
        start = 1'b0;
      end
    end
    if (v.exp_writes > 0) begin
      check("last_we", 32'(mem_we), 32'd1);
      check("last_addr", 32'(mem_addr), 32'(v.exp_writes - 1));
      check("last_data", mem_wdata, v.words[v.exp_writes - 1]);
      check("last_words", 32'(words_loaded), 32'(v.exp_writes));
      check("last_done_early", 32'(done), 32'd0);
      step();
      check("post_we", 32'(mem_we), 32'd0);
    end
    check("end_done", 32'(done), 32'(v.exp_done));
    check("end_error", 32'(error), 32'(v.exp_error));
    check("end_hold", 32'(cpu_hold), 32'(!v.exp_done));
    check("end_ready", 32'(in_ready), 32'd0);
    check("end_words", 32'(words_loaded), 32'(v.exp_writes));
    // Offer a byte in the final state: it must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) step();
    in_valid = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd0);
    check("log_size", 32'(wr_log.size()), 32'(DEPTH + v.exp_writes));
    for (int i = 0; i < wr_log.size() && i < DEPTH + v.exp_writes; i++) begin
      if (i < DEPTH) begin
        check("clr_addr", 32'(wr_log[i].addr), 32'(i));
        check("clr_data", wr_log[i].data, 32'd0);
      end else begin
        check("pay_addr", 32'(wr_log[i].addr), 32'(i - DEPTH));
        check("pay_data", wr_log[i].data, v.words[i - DEPTH]);
      end
    end
    k = idx;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    for (int i = 0; i < 7; i++) begin
      vecs[i].words     = '0;
      vecs[i].gap       = 0;
      vecs[i].start_mid = 1'b0;
    end
    // 1: two words, back-to-back bytes
    vecs[0].hdr_hi = 8'h00; vecs[0].hdr_lo = 8'h02; vecs[0].n_words = 2;
    vecs[0].words[0] = 32'h0000_0013; vecs[0].words[1] = 32'hDEAD_BEEF;
    vecs[0].exp_done = 1'b1; vecs[0].exp_error = 1'b0; vecs[0].exp_writes = 2;
    // 2: count 9 exceeds depth 8
    vecs[1].hdr_hi = 8'h00; vecs[1].hdr_lo = 8'h09; vecs[1].n_words = 0;
    vecs[1].exp_done = 1'b0; vecs[1].exp_error = 1'b1; vecs[1].exp_writes = 0;
    // 3: empty program
    vecs[2].hdr_hi = 8'h00; vecs[2].hdr_lo = 8'h00; vecs[2].n_words = 0;
    vecs[2].exp_done = 1'b1; vecs[2].exp_error = 1'b0; vecs[2].exp_writes = 0;
    // 4: same as 1 with in_valid every third cycle
    vecs[3] = vecs[0];
    vecs[3].gap = 2;
    // full depth
    vecs[4].hdr_hi = 8'h00; vecs[4].hdr_lo = 8'h08; vecs[4].n_words = 8;
    vecs[4].words[0] = 32'h1122_3344; vecs[4].words[1] = 32'h5566_7788;
    vecs[4].words[2] = 32'h99AA_BBCC; vecs[4].words[3] = 32'hDDEE_FF00;
    vecs[4].words[4] = 32'h0102_0304; vecs[4].words[5] = 32'h0506_0708;
    vecs[4].words[6] = 32'h090A_0B0C; vecs[4].words[7] = 32'h0D0E_0F10;
    vecs[4].exp_done = 1'b1; vecs[4].exp_error = 1'b0; vecs[4].exp_writes = 8;
    // 6: start pulsed mid-load is ignored
    vecs[5] = vecs[0];
    vecs[5].start_mid = 1'b1;
    // high header byte matters: 0x0100 exceeds depth
    vecs[6].hdr_hi = 8'h01; vecs[6].hdr_lo = 8'h00; vecs[6].n_words = 0;
    vecs[6].exp_done = 1'b0; vecs[6].exp_error = 1'b1; vecs[6].exp_writes = 0;

    repeat (3) step();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // 5: reset after five payload bytes, then reload scenario 1 from IDLE
    pulse_start_and_clear();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'hDE, 0);
    check("mid_words", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_ready", 32'(in_ready), 32'd0);
    check("mrst_we", 32'(mem_we), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_wdata", mem_wdata, 32'd0);
    check("mrst_hold", 32'(cpu_hold), 32'd1);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_words", 32'(words_loaded), 32'd0);
    step();
    run_vec(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
